// File: rtl/rc4_pkg.sv
// Shared definitions for the RC4 keystream/decrypt stage: FSM state encoding,
// the plaintext character-class limits and the plaintext validity test.
package rc4_pkg;

  typedef enum logic [3:0] {
    IDLE,
    RD_SI,
    WT_SI,
    RD_SJ,
    WT_SJ,
    WR_SI,
    WR_SJ,
    RD_F,
    WT_F,
    WR_DEC,
    NEXT,
    DONE
  } prga_state_t;

  localparam logic [7:0] ASCII_LO = 8'h61;
  localparam logic [7:0] ASCII_HI = 8'h7A;
  localparam logic [7:0] ASCII_SP = 8'h20;

  // A plaintext byte is acceptable if it is a lowercase letter or a space.
  function automatic logic is_valid_char(input logic [7:0] c);
    return ((c >= ASCII_LO) && (c <= ASCII_HI)) || (c == ASCII_SP);
  endfunction

endpackage

// File: rtl/rc4_keystream_decrypt.sv
// RC4 PRGA stage. Walks the already-scheduled S RAM, produces one keystream
// byte per message byte, XORs it with the encrypted ROM and writes the result
// to the decrypted RAM. With CHECK_ASCII set, the run stops early (key_bad=1)
// after writing the first byte that is not a lowercase letter or space.
module rc4_keystream_decrypt
  import rc4_pkg::*;
#(
  parameter int RAM_WIDTH   = 8,
  parameter int MSG_LENGTH  = 32,
  parameter int CHECK_ASCII = 1,
  localparam int AW = (MSG_LENGTH > 1) ? $clog2(MSG_LENGTH) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [RAM_WIDTH-1:0] s_q,
  output logic [7:0]           s_address,
  output logic [RAM_WIDTH-1:0] s_data,
  output logic                 s_wren,
  input  logic [RAM_WIDTH-1:0] msg_q,
  output logic [AW-1:0]        msg_address,
  output logic [AW-1:0]        dec_address,
  output logic [RAM_WIDTH-1:0] dec_data,
  output logic                 dec_wren,
  output logic                 done,
  output logic                 key_bad
);

  localparam logic [AW-1:0] K_LAST = AW'(MSG_LENGTH - 1);

  prga_state_t          state_q, state_d;
  logic [7:0]           i_q, i_d;
  logic [7:0]           j_q, j_d;
  logic [7:0]           si_q, si_d;
  logic [7:0]           sj_q, sj_d;
  logic [AW-1:0]        k_q, k_d;
  logic [RAM_WIDTH-1:0] f_q, f_d;
  logic                 abort_q, abort_d;
  logic                 done_q, done_d;
  logic                 key_bad_q, key_bad_d;
  logic [RAM_WIDTH-1:0] dec_byte;

  assign dec_byte = f_q ^ msg_q;

  // Next-state and datapath updates for the ten-cycle per-byte sequence.
  always_comb begin
    state_d   = state_q;
    i_d       = i_q;
    j_d       = j_q;
    si_d      = si_q;
    sj_d      = sj_q;
    k_d       = k_q;
    f_d       = f_q;
    abort_d   = abort_q;
    done_d    = done_q;
    key_bad_d = key_bad_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          i_d       = 8'd0;
          j_d       = 8'd0;
          k_d       = '0;
          abort_d   = 1'b0;
          done_d    = 1'b0;
          key_bad_d = 1'b0;
          state_d   = RD_SI;
        end else if (state_q == DONE) begin
          done_d    = 1'b1;
          key_bad_d = abort_q;
        end
      end
      RD_SI: begin
        i_d     = i_q + 8'd1;
        state_d = WT_SI;
      end
      WT_SI: begin
        si_d    = 8'(s_q);
        state_d = RD_SJ;
      end
      RD_SJ: begin
        j_d     = j_q + si_q;
        state_d = WT_SJ;
      end
      WT_SJ: begin
        sj_d    = 8'(s_q);
        state_d = WR_SI;
      end
      WR_SI:  state_d = WR_SJ;
      WR_SJ:  state_d = RD_F;
      RD_F:   state_d = WT_F;
      WT_F: begin
        f_d     = s_q;
        state_d = WR_DEC;
      end
      WR_DEC: begin
        if ((CHECK_ASCII != 0) && !is_valid_char(8'(dec_byte))) begin
          abort_d = 1'b1;
        end
        state_d = NEXT;
      end
      NEXT: begin
        if ((k_q == K_LAST) || abort_q) begin
          state_d = DONE;
        end else begin
          k_d     = k_q + 1'b1;
          state_d = RD_SI;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset drops straight back to IDLE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      i_q       <= 8'd0;
      j_q       <= 8'd0;
      si_q      <= 8'd0;
      sj_q      <= 8'd0;
      k_q       <= '0;
      f_q       <= '0;
      abort_q   <= 1'b0;
      done_q    <= 1'b0;
      key_bad_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      i_q       <= i_d;
      j_q       <= j_d;
      si_q      <= si_d;
      sj_q      <= sj_d;
      k_q       <= k_d;
      f_q       <= f_d;
      abort_q   <= abort_d;
      done_q    <= done_d;
      key_bad_q <= key_bad_d;
    end
  end

  // S RAM port: address/data/enable selected by the current state.
  always_comb begin
    s_address = 8'd0;
    s_data    = '0;
    s_wren    = 1'b0;
    case (state_q)
      RD_SI:  s_address = i_q + 8'd1;
      RD_SJ:  s_address = j_q + si_q;
      WR_SI: begin
        s_address = i_q;
        s_data    = RAM_WIDTH'(sj_q);
        s_wren    = 1'b1;
      end
      WR_SJ: begin
        s_address = j_q;
        s_data    = RAM_WIDTH'(si_q);
        s_wren    = 1'b1;
      end
      RD_F:   s_address = si_q + sj_q;
      default: s_address = 8'd0;
    endcase
  end

  // Decrypted RAM write port: one pulse per byte in WR_DEC.
  always_comb begin
    dec_data = '0;
    dec_wren = 1'b0;
    if (state_q == WR_DEC) begin
      dec_data = dec_byte;
      dec_wren = 1'b1;
    end
  end

  assign msg_address = k_q;
  assign dec_address = k_q;
  assign done        = done_q;
  assign key_bad     = key_bad_q;

endmodule

// File: tb/tb_rc4_keystream_decrypt.sv
// Directed bench for rc4_keystream_decrypt. Instance A runs 32-byte messages
// with the plaintext check enabled; instance B runs 9-byte messages without it.
module tb_rc4_keystream_decrypt;

  localparam int LEN_A = 32;
  localparam int LEN_B = 9;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic       start_a, start_b;
  logic [7:0] s_q_a, s_address_a, s_data_a, msg_q_a, dec_data_a;
  logic       s_wren_a, dec_wren_a, done_a, key_bad_a;
  logic [4:0] msg_address_a, dec_address_a;
  logic [7:0] s_q_b, s_address_b, s_data_b, msg_q_b, dec_data_b;
  logic       s_wren_b, dec_wren_b, done_b, key_bad_b;
  logic [3:0] msg_address_b, dec_address_b;

  logic [7:0] s_init    [256];
  logic [7:0] s_mem_a   [256];
  logic [7:0] s_mem_b   [256];
  logic [7:0] rom_a     [LEN_A];
  logic [7:0] dec_mem_a [LEN_A];
  logic [7:0] rom_b     [16];
  logic [7:0] dec_mem_b [16];
  logic       load_a, load_b, clr_a;

  int cycle;
  int wren_cnt_a;
  int last_wren_a;
  int gap_err_a;
  int n_checks = 0;
  int n_errors = 0;

  rc4_keystream_decrypt #(.RAM_WIDTH(8), .MSG_LENGTH(LEN_A), .CHECK_ASCII(1)) dut_a (
    .clk(clk), .reset(reset), .start(start_a),
    .s_q(s_q_a), .s_address(s_address_a), .s_data(s_data_a), .s_wren(s_wren_a),
    .msg_q(msg_q_a), .msg_address(msg_address_a),
    .dec_address(dec_address_a), .dec_data(dec_data_a), .dec_wren(dec_wren_a),
    .done(done_a), .key_bad(key_bad_a)
  );

  rc4_keystream_decrypt #(.RAM_WIDTH(8), .MSG_LENGTH(LEN_B), .CHECK_ASCII(0)) dut_b (
    .clk(clk), .reset(reset), .start(start_b),
    .s_q(s_q_b), .s_address(s_address_b), .s_data(s_data_b), .s_wren(s_wren_b),
    .msg_q(msg_q_b), .msg_address(msg_address_b),
    .dec_address(dec_address_b), .dec_data(dec_data_b), .dec_wren(dec_wren_b),
    .done(done_b), .key_bad(key_bad_b)
  );

  // Free-running edge counter used to measure spacing of decrypted writes.
  always @(posedge clk) cycle <= cycle + 1;

  // Memories around instance A, plus write-pulse counting and spacing check.
  always @(posedge clk) begin
    if (load_a) begin
      for (int x = 0; x < 256; x++) s_mem_a[x] <= s_init[x];
    end else if (s_wren_a) begin
      s_mem_a[s_address_a] <= s_data_a;
    end
    s_q_a   <= s_mem_a[s_address_a];
    msg_q_a <= rom_a[msg_address_a];
    if (clr_a) begin
      wren_cnt_a  <= 0;
      last_wren_a <= -1;
      gap_err_a   <= 0;
      for (int x = 0; x < LEN_A; x++) dec_mem_a[x] <= 8'hEE;
    end else if (dec_wren_a) begin
      dec_mem_a[dec_address_a] <= dec_data_a;
      wren_cnt_a  <= wren_cnt_a + 1;
      last_wren_a <= cycle;
      if ((last_wren_a >= 0) && (cycle - last_wren_a != 10)) gap_err_a <= gap_err_a + 1;
    end
  end

  // Memories around instance B.
  always @(posedge clk) begin
    if (load_b) begin
      for (int x = 0; x < 256; x++) s_mem_b[x] <= s_init[x];
    end else if (s_wren_b) begin
      s_mem_b[s_address_b] <= s_data_b;
    end
    s_q_b   <= s_mem_b[s_address_b];
    msg_q_b <= rom_b[msg_address_b];
    if (dec_wren_b) dec_mem_b[dec_address_b] <= dec_data_b;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Pulse start for one edge on the chosen instance (0=A, 1=B).
  task automatic applyStimulus(input bit use_b);
    if (use_b) start_b = 1'b1;
    else start_a = 1'b1;
    tick(1);
    start_a = 1'b0;
    start_b = 1'b0;
  endtask

  task automatic loadS(input bit use_b);
    if (use_b) load_b = 1'b1;
    else load_a = 1'b1;
    tick(1);
    load_a = 1'b0;
    load_b = 1'b0;
  endtask

  task automatic clearA();
    clr_a = 1'b1;
    tick(1);
    clr_a = 1'b0;
  endtask

  task automatic waitDone(input bit use_b, input int budget, output int edges);
    edges = 0;
    while (!(use_b ? done_b : done_a) && (edges < budget)) begin
      tick(1);
      edges++;
    end
  endtask

  logic [7:0] pt [LEN_A];
  logic [7:0] ks [LEN_A];
  logic [7:0] ms [256];
  logic [7:0] key [3];
  logic [7:0] exp_b [LEN_B];
  logic [7:0] enc_b [LEN_B];

  initial begin
    int edges;
    logic [7:0] ii, jj, tmp;

    reset = 1'b1;
    start_a = 1'b0;
    start_b = 1'b0;
    load_a = 1'b0;
    load_b = 1'b0;
    clr_a = 1'b0;
    for (int x = 0; x < 256; x++) s_init[x] = 8'(x);
    for (int x = 0; x < 16; x++) rom_b[x] = 8'h00;

    // Plaintext for instance A runs, and its ciphertext under the identity S.
    for (int x = 0; x < 256; x++) ms[x] = 8'(x);
    ii = 0;
    jj = 0;
    for (int k = 0; k < LEN_A; k++) begin
      ii = ii + 8'd1;
      jj = jj + ms[ii];
      tmp = ms[ii];
      ms[ii] = ms[jj];
      ms[jj] = tmp;
      ks[k] = ms[8'(ms[ii] + ms[jj])];
      pt[k] = ((k % 7) == 6) ? 8'h20 : 8'(8'h61 + (k % 26));
      rom_a[k] = ks[k] ^ pt[k];
    end

    tick(2);
    checkOutput("reset_outputs_a",
                {s_address_a, s_data_a, s_wren_a, msg_address_a, dec_address_a, dec_data_a, dec_wren_a, done_a, key_bad_a}, 64'd0);
    checkOutput("reset_outputs_b",
                {s_address_b, s_data_b, s_wren_b, msg_address_b, dec_address_b, dec_data_b, dec_wren_b, done_b, key_bad_b}, 64'd0);
    reset = 1'b0;
    tick(1);

    $display("[TB] identity S, ROM 63 62 on instance B");
    rom_b[0] = 8'h63;
    rom_b[1] = 8'h62;
    loadS(1'b1);
    applyStimulus(1'b1);
    waitDone(1'b1, 200, edges);
    checkOutput("t1_latency", 64'(edges), 64'd91);
    checkOutput("t1_dec0", 64'(dec_mem_b[0]), 64'h61);
    checkOutput("t1_dec1", 64'(dec_mem_b[1]), 64'h67);
    checkOutput("t1_s2", 64'(s_mem_b[2]), 64'h03);
    checkOutput("t1_key_bad", 64'(key_bad_b), 64'd0);

    $display("[TB] KSA key 4B6579, Plaintext vector on instance B");
    key[0] = 8'h4B;
    key[1] = 8'h65;
    key[2] = 8'h79;
    for (int x = 0; x < 256; x++) s_init[x] = 8'(x);
    jj = 0;
    for (int x = 0; x < 256; x++) begin
      jj = jj + s_init[x] + key[x % 3];
      tmp = s_init[x];
      s_init[x] = s_init[jj];
      s_init[jj] = tmp;
    end
    enc_b = '{8'hBB, 8'hF3, 8'h16, 8'hE8, 8'hD9, 8'h40, 8'hAF, 8'h0A, 8'hD3};
    exp_b = '{8'h50, 8'h6C, 8'h61, 8'h69, 8'h6E, 8'h74, 8'h65, 8'h78, 8'h74};
    for (int x = 0; x < LEN_B; x++) rom_b[x] = enc_b[x];
    loadS(1'b1);
    applyStimulus(1'b1);
    waitDone(1'b1, 200, edges);
    checkOutput("t2_done", 64'(done_b), 64'd1);
    for (int x = 0; x < LEN_B; x++) checkOutput($sformatf("t2_dec%0d", x), 64'(dec_mem_b[x]), 64'(exp_b[x]));
    checkOutput("t2_key_bad", 64'(key_bad_b), 64'd0);

    $display("[TB] bad first byte on instance A");
    for (int x = 0; x < 256; x++) s_init[x] = 8'(x);
    rom_a[0] = 8'h02;
    loadS(1'b0);
    clearA();
    applyStimulus(1'b0);
    waitDone(1'b0, 400, edges);
    checkOutput("t3_latency", 64'(edges), 64'd11);
    checkOutput("t3_dec0", 64'(dec_mem_a[0]), 64'h00);
    checkOutput("t3_wren_count", 64'(wren_cnt_a), 64'd1);
    checkOutput("t3_key_bad", 64'(key_bad_a), 64'd1);
    tick(5);
    checkOutput("t3_dec1_untouched", 64'(dec_mem_a[1]), 64'hEE);

    $display("[TB] full 32-byte run, restarted from DONE");
    rom_a[0] = ks[0] ^ pt[0];
    loadS(1'b0);
    clearA();
    applyStimulus(1'b0);
    checkOutput("t6_restart_clear", {62'd0, done_a, key_bad_a}, 64'd0);
    waitDone(1'b0, 400, edges);
    checkOutput("t4_latency", 64'(edges), 64'd321);
    checkOutput("t4_wren_count", 64'(wren_cnt_a), 64'd32);
    checkOutput("t4_wren_gaps", 64'(gap_err_a), 64'd0);
    checkOutput("t4_key_bad", 64'(key_bad_a), 64'd0);
    for (int k = 0; k < LEN_A; k++) checkOutput($sformatf("t4_dec%0d", k), 64'(dec_mem_a[k]), 64'(pt[k]));

    $display("[TB] reset in the middle of a run");
    loadS(1'b0);
    clearA();
    applyStimulus(1'b0);
    tick(56);
    checkOutput("t5_in_progress_k", 64'(msg_address_a), 64'd5);
    reset = 1'b1;
    #1;
    checkOutput("t5_outputs_zero",
                {s_address_a, s_data_a, s_wren_a, msg_address_a, dec_address_a, dec_data_a, dec_wren_a, done_a, key_bad_a}, 64'd0);
    tick(3);
    checkOutput("t5_no_more_writes", 64'(wren_cnt_a), 64'd5);
    reset = 1'b0;
    tick(1);
    loadS(1'b0);
    clearA();
    applyStimulus(1'b0);
    waitDone(1'b0, 400, edges);
    checkOutput("t5_rerun_latency", 64'(edges), 64'd321);
    for (int k = 0; k < LEN_A; k++) checkOutput($sformatf("t5_dec%0d", k), 64'(dec_mem_a[k]), 64'(pt[k]));

    $display("[TB] start pulsed during WR_SI is ignored");
    loadS(1'b0);
    clearA();
    applyStimulus(1'b0);
    tick(4);
    start_a = 1'b1;
    tick(1);
    start_a = 1'b0;
    waitDone(1'b0, 400, edges);
    checkOutput("t6_latency", 64'(edges), 64'd316);
    checkOutput("t6_wren_count", 64'(wren_cnt_a), 64'd32);
    checkOutput("t6_dec0", 64'(dec_mem_a[0]), 64'(pt[0]));
    checkOutput("t6_dec31", 64'(dec_mem_a[31]), 64'(pt[31]));
    applyStimulus(1'b0);
    checkOutput("t6_done_cleared", 64'(done_a), 64'd0);
    tick(8);
    checkOutput("t6_new_run_wren", {62'd0, dec_wren_a, 1'b0} | 64'(msg_address_a), 64'd2);

    reset = 1'b1;
    tick(2);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
